// File: rtl/arb_pkg.sv
// Shared types for the arbiter output stage: mode encoding, buffered entry layout, transfer FSM states.
package arb_pkg;

   localparam int unsigned ARB_DW = 32;
   localparam int unsigned ARB_MW = 2;

   typedef logic [ARB_MW-1:0] mode_t;
   localparam mode_t MODE_NOP = '0;

   typedef struct packed {
      logic                src;
      logic                proc_val;
      mode_t               mode;
      logic [ARB_DW-1:0]   data;
   } arb_entry_t;

   localparam int unsigned ENTRY_W = $bits(arb_entry_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CMPLT = 2'd2
   } xfer_state_t;

endpackage

// File: rtl/arb_fifo_mem.sv
// Entry storage for the output FIFO: one synchronous write port, one asynchronous read port.
module arb_fifo_mem
   import arb_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  arb_entry_t       wr_data,
   input  logic [AW-1:0]    rd_addr,
   output arb_entry_t       rd_data
);

   arb_entry_t mem [DEPTH];

   // Cleared on reset so the head fields read as zero until something is written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/arb_out_fifo.sv
// Buffers the arbitrated word stream, back-pressures the arbiter, and counts a transfer to completion.
module arb_out_fifo
   import arb_pkg::*;
#(
   parameter int unsigned DW    = ARB_DW,
   parameter int unsigned MW    = ARB_MW,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned SKID  = 2,
   parameter int unsigned LENW  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     slvx_data_valid,
   input  logic [MW-1:0]            slvx_mode,
   input  logic                     slvx_proc_val,
   input  logic [DW-1:0]            slvx_data,
   input  logic                     data_source,
   output logic                     fifo_full,
   output logic                     mstr_valid,
   input  logic                     mstr_ready,
   output logic [DW-1:0]            mstr_data,
   output logic [MW-1:0]            mstr_mode,
   output logic                     mstr_proc_val,
   output logic                     mstr_src,
   input  logic [LENW-1:0]          cfg_len,
   input  logic                     start,
   input  logic                     cmplt_ack,
   output logic                     mstr0_cmplt,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count_next;
   logic [LENW-1:0] remain;
   logic [LENW-1:0] remain_next;
   xfer_state_t     state;
   xfer_state_t     state_next;
   logic            wr_req;
   logic            wr_en;
   logic            rd_en;
   arb_entry_t      wr_entry;
   arb_entry_t      head;

   // A read in the same cycle never frees room for the write: acceptance looks at count only.
   always_comb begin
      wr_req            = slvx_data_valid && (mode_t'(ARB_MW'(slvx_mode)) != MODE_NOP);
      wr_en             = wr_req && (count < CW'(DEPTH));
      rd_en             = mstr_valid && mstr_ready;
      count_next        = count + CW'(wr_en) - CW'(rd_en);
      wr_entry.src      = data_source;
      wr_entry.proc_val = slvx_proc_val;
      wr_entry.mode     = mode_t'(ARB_MW'(slvx_mode));
      wr_entry.data     = ARB_DW'(slvx_data);
   end

   // Transfer sequencing: length load on start, countdown on handshakes, hold until acknowledged.
   always_comb begin
      state_next  = state;
      remain_next = remain;
      case (state)
         IDLE: begin
            if (start) begin
               remain_next = cfg_len;
               state_next  = (cfg_len == '0) ? CMPLT : RUN;
            end
         end
         RUN: begin
            if (rd_en) begin
               remain_next = remain - LENW'(1);
               if (remain == LENW'(1)) begin
                  state_next = CMPLT;
               end
            end
         end
         CMPLT: begin
            if (cmplt_ack) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         remain      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         fifo_full   <= 1'b0;
         overflow    <= 1'b0;
         mstr_valid  <= 1'b0;
         mstr0_cmplt <= 1'b0;
      end else begin
         state       <= state_next;
         remain      <= remain_next;
         count       <= count_next;
         fifo_full   <= (count_next >= CW'(DEPTH - SKID));
         overflow    <= overflow | (wr_req && !wr_en);
         mstr_valid  <= (state_next == RUN) && (count_next != '0);
         mstr0_cmplt <= (state_next == CMPLT);
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   arb_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // Head fields are visible whether or not a transfer is running.
   assign mstr_data     = DW'(head.data);
   assign mstr_mode     = MW'(head.mode);
   assign mstr_proc_val = head.proc_val;
   assign mstr_src      = head.src;

endmodule
